// File: rtl/univ_shift_reg.sv
// WIDTH-bit general-purpose register and shifter with complementary outputs.
// Each shift/rotate runs one bit position per clock, using a start/busy/done handshake.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_SHL   = 3'b010;
   localparam logic [2:0] OP_SHR   = 3'b011;
   localparam logic [2:0] OP_ROL   = 3'b100;
   localparam logic [2:0] OP_ROR   = 3'b101;
   localparam logic [2:0] OP_ASR   = 3'b110;
   localparam logic [2:0] OP_CLEAR = 3'b111;

   state_t           state, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [AMT_W-1:0] rem, rem_next;
   logic [2:0]       op_reg, op_next;

   // One bit-position step of a shift mode; serial fills are taken live each edge.
   function automatic logic [WIDTH-1:0] shift_once(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] val,
                                                   input logic fill_l,
                                                   input logic fill_r);
      logic [WIDTH-1:0] res;
      res = val;
      case (op)
         OP_SHL:  res = {val[WIDTH-2:0], fill_r};
         OP_SHR:  res = {fill_l, val[WIDTH-1:1]};
         OP_ROL:  res = {val[WIDTH-2:0], val[WIDTH-1]};
         OP_ROR:  res = {val[0], val[WIDTH-1:1]};
         OP_ASR:  res = {val[WIDTH-1], val[WIDTH-1:1]};
         default: res = val;
      endcase
      return res;
   endfunction

   function automatic logic is_shift(input logic [2:0] op);
      return (op >= OP_SHL) && (op <= OP_ASR);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         q_reg  <= '0;
         rem    <= '0;
         op_reg <= OP_HOLD;
      end else begin
         state  <= state_next;
         q_reg  <= q_next;
         rem    <= rem_next;
         op_reg <= op_next;
      end
   end

   // The first shift happens on the start edge itself, so rem counts the shifts still owed.
   always_comb begin
      state_next = state;
      q_next     = q_reg;
      rem_next   = rem;
      op_next    = op_reg;
      unique case (state)
         IDLE: begin
            if (start) begin
               op_next = mode;
               if (is_shift(mode) && (amt != '0)) begin
                  q_next     = shift_once(mode, q_reg, sin_l, sin_r);
                  rem_next   = amt - AMT_W'(1);
                  state_next = (amt == AMT_W'(1)) ? DONE : RUN;
               end else begin
                  case (mode)
                     OP_LOAD:  q_next = d;
                     OP_CLEAR: q_next = '0;
                     default:  q_next = q_reg;
                  endcase
                  rem_next   = '0;
                  state_next = DONE;
               end
            end
         end
         RUN: begin
            q_next   = shift_once(op_reg, q_reg, sin_l, sin_r);
            rem_next = rem - AMT_W'(1);
            if (rem == AMT_W'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign q    = q_reg;
   assign qbar = ~q_reg;
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, AMT_W=3).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_univ_shift_reg;

   logic       clock;
   logic       reset;
   logic       start;
   logic [2:0] mode;
   logic [2:0] amt;
   logic [7:0] d;
   logic       sin_l;
   logic       sin_r;
   logic [7:0] q;
   logic [7:0] qbar;
   logic       busy;
   logic       done;

   int n_checks;
   int n_fail;

   univ_shift_reg #(.WIDTH(8), .AMT_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .mode  (mode),
      .amt   (amt),
      .d     (d),
      .sin_l (sin_l),
      .sin_r (sin_r),
      .q     (q),
      .qbar  (qbar),
      .busy  (busy),
      .done  (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // q, qbar, busy and done together against one expected register value.
   task automatic checkAll(input string tag, input logic [7:0] exp_q, input logic exp_busy, input logic exp_done);
      checkOutput({tag, " q"}, q, exp_q);
      checkOutput({tag, " qbar"}, qbar, ~exp_q);
      checkOutput({tag, " busy"}, {7'b0, busy}, {7'b0, exp_busy});
      checkOutput({tag, " done"}, {7'b0, done}, {7'b0, exp_done});
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Presents one request across a single rising edge, then scrambles mode/amt/d.
   task automatic applyStimulus(input logic [2:0] m, input logic [2:0] a, input logic [7:0] data);
      @(negedge clock);
      start = 1'b1;
      mode  = m;
      amt   = a;
      d     = data;
      stepCycle();
      start = 1'b0;
      mode  = 3'b111;
      amt   = 3'b101;
      d     = 8'hEE;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b0;
      start = 1'b0;
      mode  = 3'b000;
      amt   = 3'b000;
      d     = 8'h00;
      sin_l = 1'b0;
      sin_r = 1'b0;

      #2 reset = 1'b1;
      #1 checkAll("power-on reset", 8'h00, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Load A5, then assert reset between edges
      applyStimulus(3'b001, 3'd0, 8'hA5);
      checkAll("load A5", 8'hA5, 1'b0, 1'b1);
      stepCycle();
      checkAll("load A5 idle", 8'hA5, 1'b0, 1'b0);
      #3 reset = 1'b1;
      #1 checkAll("async reset", 8'h00, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // LOAD then CLEAR
      applyStimulus(3'b001, 3'd0, 8'h3C);
      checkAll("load 3C", 8'h3C, 1'b0, 1'b1);
      stepCycle();
      checkAll("load 3C idle", 8'h3C, 1'b0, 1'b0);
      applyStimulus(3'b111, 3'd0, 8'h55);
      checkAll("clear", 8'h00, 1'b0, 1'b1);
      stepCycle();
      checkAll("clear idle", 8'h00, 1'b0, 1'b0);

      // ROL 81 by 3
      applyStimulus(3'b001, 3'd0, 8'h81);
      stepCycle();
      applyStimulus(3'b100, 3'd3, 8'h00);
      checkAll("rol step1", 8'h03, 1'b1, 1'b0);
      stepCycle();
      checkAll("rol step2", 8'h06, 1'b1, 1'b0);
      stepCycle();
      checkAll("rol step3", 8'h0C, 1'b0, 1'b1);
      stepCycle();
      checkAll("rol idle", 8'h0C, 1'b0, 1'b0);

      // ASR 90 by 7 saturates to the sign bit
      applyStimulus(3'b001, 3'd0, 8'h90);
      stepCycle();
      applyStimulus(3'b110, 3'd7, 8'h00);
      checkAll("asr step1", 8'hC8, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) stepCycle();
      checkAll("asr final", 8'hFF, 1'b0, 1'b1);
      stepCycle();

      // SHR 90 by 2, fill 1 then 0
      applyStimulus(3'b001, 3'd0, 8'h90);
      stepCycle();
      sin_l = 1'b1;
      applyStimulus(3'b011, 3'd2, 8'h00);
      sin_l = 1'b0;
      checkAll("shr step1", 8'hC8, 1'b1, 1'b0);
      stepCycle();
      checkAll("shr step2", 8'h64, 1'b0, 1'b1);
      stepCycle();

      // SHL with amt=0 leaves q unchanged
      applyStimulus(3'b010, 3'd0, 8'h00);
      checkAll("shl amt0", 8'h64, 1'b0, 1'b1);
      stepCycle();
      checkAll("shl amt0 idle", 8'h64, 1'b0, 1'b0);

      // SHL 64 by 5 with fill 1; a LOAD start during RUN is ignored
      sin_r = 1'b1;
      applyStimulus(3'b010, 3'd5, 8'h00);
      checkAll("shl5 step1", 8'hC9, 1'b1, 1'b0);
      @(negedge clock);
      start = 1'b1;
      mode  = 3'b001;
      d     = 8'h00;
      stepCycle();
      start = 1'b0;
      checkAll("shl5 step2 start ignored", 8'h93, 1'b1, 1'b0);
      stepCycle();
      stepCycle();
      checkAll("shl5 step4", 8'h4F, 1'b1, 1'b0);
      stepCycle();
      checkAll("shl5 final", 8'h9F, 1'b0, 1'b1);
      sin_r = 1'b0;
      stepCycle();
      checkAll("shl5 idle", 8'h9F, 1'b0, 1'b0);

      // ROR F0 by 6 aborted by reset after the second shift
      applyStimulus(3'b001, 3'd0, 8'hF0);
      stepCycle();
      applyStimulus(3'b101, 3'd6, 8'h00);
      checkAll("ror step1", 8'h78, 1'b1, 1'b0);
      stepCycle();
      checkAll("ror step2", 8'h3C, 1'b1, 1'b0);
      reset = 1'b1;
      #1 checkAll("ror abort", 8'h00, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      stepCycle();
      checkAll("after abort no done", 8'h00, 1'b0, 1'b0);
      stepCycle();
      checkAll("after abort idle", 8'h00, 1'b0, 1'b0);

      // Normal operation after the abort, including a distance-1 rotate
      applyStimulus(3'b001, 3'd0, 8'h5A);
      checkAll("reload 5A", 8'h5A, 1'b0, 1'b1);
      stepCycle();
      applyStimulus(3'b101, 3'd1, 8'h00);
      checkAll("ror1", 8'h2D, 1'b0, 1'b1);
      stepCycle();
      checkAll("ror1 idle", 8'h2D, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised N-bit storage register with complementary outputs.
- Generalises the single-bit gated D latch to an edge-triggered WIDTH-bit register with an asynchronous clear.
- Adds parallel load, clear, and multi-cycle shift/rotate operations of a programmable distance.
- Operations use a start/busy/done handshake and run one bit position per clock.
- Sits in the datapath labs as the general-purpose register and shifter under the board-level top modules (switch inputs, LED outputs).

Parameters:
WIDTH, 8, register width in bits (≥2)
AMT_W, 3, width of the shift-distance input; maximum distance 2^AMT_W-1

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request an operation; sampled only in IDLE
mode  input  3  operation code, captured with start
amt  input  AMT_W  shift distance, captured with start
d  input  WIDTH  parallel load data, sampled on the start edge
sin_l  input  1  serial fill bit entering the MSB on SHR
sin_r  input  1  serial fill bit entering the LSB on SHL
q  output  WIDTH  register contents
qbar  output  WIDTH  bitwise complement of q (combinational)
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse (high in DONE)

Behaviour:
- One clock (clock). Reset is asynchronous and active-high (reset).
- While reset is high: q=0, qbar=all ones, busy=0, done=0, state=IDLE, internal counter=0. This holds regardless of clock.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced.
- Mode encoding:
  - 000 HOLD
  - 001 LOAD (q←d)
  - 010 SHL (q←{q[W-2:0],sin_r})
  - 011 SHR (q←{sin_l,q[W-1:1]})
  - 100 ROL (q←{q[W-2:0],q[W-1]})
  - 101 ROR (q←{q[0],q[W-1:1]})
  - 110 ASR (q←{q[W-1],q[W-1:1]})
  - 111 CLEAR (q←0)
- Shift modes are 010 to 110. All other modes are single-step modes.
- State machine has three states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - mode and amt are captured.
  - Single-step mode, or shift mode with amt=0: the operation is applied at edge k (HOLD/amt=0 leave q unchanged). Next state is DONE.
  - Shift mode with amt≥1: the first shift is applied at edge k and rem←amt-1. Next state is DONE if amt=1, else RUN.
- IDLE, start=0: q holds.
- RUN:
  - Each edge applies one shift of the captured mode and sets rem←rem-1.
  - If rem was 1 before the edge, next state is DONE.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Resulting latency: a shift of distance n≥1 updates q on edges k..k+n-1, and done is high in the cycle following edge k+n-1. Single-step ops give done in the cycle after edge k.
- start is ignored in RUN and DONE. A new start is accepted in IDLE no earlier than the cycle after done.
- mode, amt and d changes after edge k have no effect.
- sin_l and sin_r are sampled live at each shift edge. They are not latched.
- Distances ≥WIDTH are legal:
  - SHL/SHR fully replace q with fill bits.
  - ASR saturates to all copies of the sign bit.
  - ROL/ROR by WIDTH return the original value.
- qbar == ~q at all times, including during reset.

Test Plan:
- Reset: assert reset asynchronously between edges with q=8'hA5 -> q=8'h00, qbar=8'hFF, busy=0, done=0 immediately, without a clock edge.
- LOAD then CLEAR: start, mode=001, d=8'h3C -> q=8'h3C after the edge and done high one cycle. Then mode=111 -> q=8'h00 and done pulse.
- Multi-cycle ROL: q=8'h81, mode=100, amt=3 -> q steps 8'h03, 8'h06, 8'h0C on three edges. busy high for 2 cycles, then done high for 1 cycle.
- ASR and SHR fill: q=8'h90, ASR amt=7 -> 8'hFF. Reload 8'h90, SHR amt=2 with sin_l=1 then 0 -> 8'hC8 then 8'h64.
- amt=0 and ignored start: SHL amt=0 -> q unchanged and done next cycle. Start with mode=001 pulsed during RUN of a 5-step SHL -> ignored, and the final q equals 5 pure shifts.
- Reset mid-operation: ROR amt=6 from 8'hF0, reset after the 2nd shift -> q=0 and state IDLE. No done pulse. The next start operates normally.
